// File: rtl/wb_b3_burst_master_if.sv
// Command, write/read data streams and Wishbone B3 master signals for the burst master.
interface wb_b3_burst_master_if #(
  parameter int dw = 32,
  parameter int aw = 32
);
  logic          cmd_valid_i;
  logic          cmd_ready_o;
  logic          cmd_we_i;
  logic [aw-1:0] cmd_adr_i;
  logic [3:0]    cmd_len_i;
  logic [1:0]    cmd_bte_i;

  logic [dw-1:0] wr_data_i;
  logic          wr_valid_i;
  logic          wr_ready_o;

  logic [dw-1:0] rd_data_o;
  logic          rd_valid_o;
  logic          done_o;
  logic          err_o;

  logic [aw-1:0] wb_adr_o;
  logic [dw-1:0] wb_dat_o;
  logic [3:0]    wb_sel_o;
  logic          wb_we_o;
  logic [1:0]    wb_bte_o;
  logic [2:0]    wb_cti_o;
  logic          wb_cyc_o;
  logic          wb_stb_o;
  logic [dw-1:0] wb_dat_i;
  logic          wb_ack_i;
  logic          wb_err_i;
  logic          wb_rty_i;

  modport master (
    input  cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_len_i, cmd_bte_i,
    input  wr_data_i, wr_valid_i,
    input  wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i,
    output cmd_ready_o, wr_ready_o, rd_data_o, rd_valid_o, done_o, err_o,
    output wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_bte_o, wb_cti_o, wb_cyc_o, wb_stb_o
  );

  modport slave (
    output cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_len_i, cmd_bte_i,
    output wr_data_i, wr_valid_i,
    output wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i,
    input  cmd_ready_o, wr_ready_o, rd_data_o, rd_valid_o, done_o, err_o,
    input  wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_bte_o, wb_cti_o, wb_cyc_o, wb_stb_o
  );
endinterface

// File: rtl/wb_b3_burst_master.sv
// Wishbone B3 burst master: one 1..16 beat linear/wrap burst per command, cyc one cycle after accept.
// Write beats stall on wr_valid_i (stb follows it); read data appears one cycle after ack, no backpressure.
module wb_b3_burst_master #(
  parameter int dw = 32,
  parameter int aw = 32
) (
  input logic                  wb_clk_i,
  input logic                  wb_rst_i,
  wb_b3_burst_master_if.master bus
);

  localparam int WW = aw - 2;

  typedef enum logic [1:0] {IDLE, BUS, RTY_WAIT} state_t;

  state_t        state;
  logic [3:0]    beats_left;
  logic [dw-1:0] rd_data_q;
  logic [WW-1:0] word_adr, word_inc, word_mask, word_next;
  logic          stb, term_err, term_ack, term_rty, last_beat;

  assign stb       = (state == BUS) && (bus.wb_we_o ? bus.wr_valid_i : 1'b1);
  assign term_err  = stb & bus.wb_err_i;
  assign term_ack  = stb & bus.wb_ack_i & ~bus.wb_err_i;
  assign term_rty  = stb & bus.wb_rty_i & ~bus.wb_ack_i & ~bus.wb_err_i;
  assign last_beat = (beats_left == 4'd0);

  assign bus.cmd_ready_o = (state == IDLE);
  assign bus.wb_stb_o    = stb;
  assign bus.wb_dat_o    = bus.wr_data_i;
  assign bus.wb_sel_o    = bus.wb_cyc_o ? 4'hf : 4'h0;
  assign bus.wr_ready_o  = bus.wb_ack_i & stb & bus.wb_we_o;
  assign bus.rd_data_o   = rd_data_q;

  // Wrapping bursts only count within the low word-address bits; linear carries through all.
  assign word_adr = bus.wb_adr_o[aw-1:2];
  assign word_inc = word_adr + WW'(1);
  always_comb begin
    word_mask = '1;
    case (bus.wb_bte_o)
      2'b01:   word_mask = WW'(4'h3);
      2'b10:   word_mask = WW'(4'h7);
      2'b11:   word_mask = WW'(4'hf);
      default: word_mask = '1;
    endcase
  end
  assign word_next = (word_adr & ~word_mask) | (word_inc & word_mask);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state          <= IDLE;
      beats_left     <= 4'd0;
      rd_data_q      <= '0;
      bus.wb_cyc_o   <= 1'b0;
      bus.wb_we_o    <= 1'b0;
      bus.wb_cti_o   <= 3'b000;
      bus.wb_bte_o   <= 2'b00;
      bus.wb_adr_o   <= '0;
      bus.rd_valid_o <= 1'b0;
      bus.done_o     <= 1'b0;
      bus.err_o      <= 1'b0;
    end else begin
      bus.rd_valid_o <= 1'b0;
      bus.done_o     <= 1'b0;
      bus.err_o      <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.cmd_valid_i) begin
            state        <= BUS;
            bus.wb_cyc_o <= 1'b1;
            bus.wb_we_o  <= bus.cmd_we_i;
            bus.wb_bte_o <= bus.cmd_bte_i;
            bus.wb_adr_o <= bus.cmd_adr_i & ~aw'(3);
            beats_left   <= bus.cmd_len_i;
            bus.wb_cti_o <= (bus.cmd_len_i == 4'd0) ? 3'b000 : 3'b010;
          end
        end
        BUS: begin
          if (term_err) begin
            state        <= IDLE;
            bus.wb_cyc_o <= 1'b0;
            bus.err_o    <= 1'b1;
          end else if (term_ack) begin
            if (!bus.wb_we_o) begin
              bus.rd_valid_o <= 1'b1;
              rd_data_q      <= bus.wb_dat_i;
            end
            if (last_beat) begin
              state        <= IDLE;
              bus.wb_cyc_o <= 1'b0;
              bus.done_o   <= 1'b1;
            end else begin
              bus.wb_adr_o <= {word_next, 2'b00};
              beats_left   <= beats_left - 4'd1;
              bus.wb_cti_o <= (beats_left == 4'd1) ? 3'b111 : 3'b010;
            end
          end else if (term_rty) begin
            state <= RTY_WAIT;
          end
        end
        RTY_WAIT: state <= BUS;
        default:  state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_b3_burst_master.sv
// Scoreboard bench: directed bursts push expected beats/read data/completions; a monitor pops and compares.
module tb_wb_b3_burst_master;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_b3_burst_master_if #(.dw(32), .aw(32)) bus ();

  wb_b3_burst_master #(.dw(32), .aw(32)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .bus      (bus)
  );

  typedef struct {
    logic [31:0] adr;
    logic [2:0]  cti;
    logic        we;
    logic [1:0]  bte;
    logic [31:0] dat;
  } beat_t;

  beat_t       exp_beat[$];
  logic [31:0] exp_rd[$];
  bit          exp_end[$];   // 1 = done, 0 = err

  int n_checks = 0;
  int n_fail   = 0;

  // Slave model: acks every strobed cycle unless an err/rty is scripted for this beat index.
  int err_at = -1;
  int rty_at = -1;
  int beat_idx = 0;
  bit rty_used = 1'b0;
  logic hit;

  assign hit          = bus.wb_cyc_o && bus.wb_stb_o;
  assign bus.wb_err_i = hit && (beat_idx == err_at);
  assign bus.wb_rty_i = hit && (beat_idx == rty_at) && !rty_used && !bus.wb_err_i;
  assign bus.wb_ack_i = hit && !bus.wb_err_i && !bus.wb_rty_i;
  assign bus.wb_dat_i = bus.wb_adr_o + 32'h1000_0000;

  always @(posedge clk) begin
    if (bus.cmd_valid_i && bus.cmd_ready_o) begin
      beat_idx <= 0;
      rty_used <= 1'b0;
    end else begin
      if (bus.wb_ack_i) beat_idx <= beat_idx + 1;
      if (bus.wb_rty_i) rty_used <= 1'b1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_beat(input logic [31:0] adr, input logic [2:0] cti, input logic we,
                           input logic [1:0] bte, input logic [31:0] dat);
    beat_t b;
    b.adr = adr; b.cti = cti; b.we = we; b.bte = bte; b.dat = dat;
    exp_beat.push_back(b);
  endtask

  // Monitor samples 2 time units after the falling edge so stimulus driven at that edge has settled.
  bit prev_rty = 1'b0;
  always begin
    @(negedge clk);
    #2;
    if (prev_rty) begin
      chk("rty_stb_low", bus.wb_stb_o, 1'b0);
      chk("rty_cyc_high", bus.wb_cyc_o, 1'b1);
    end
    prev_rty = hit && bus.wb_rty_i;
    if (hit && (bus.wb_ack_i || bus.wb_err_i || bus.wb_rty_i)) begin
      if (exp_beat.size() == 0) begin
        chk("beat_unexpected", bus.wb_adr_o, 32'hFFFF_FFFF);
      end else begin
        beat_t e;
        e = exp_beat.pop_front();
        chk("beat_adr", bus.wb_adr_o, e.adr);
        chk("beat_cti", {29'd0, bus.wb_cti_o}, {29'd0, e.cti});
        chk("beat_we", bus.wb_we_o, e.we);
        chk("beat_bte", {30'd0, bus.wb_bte_o}, {30'd0, e.bte});
        chk("beat_sel", {28'd0, bus.wb_sel_o}, 32'hf);
        if (e.we) chk("beat_wdat", bus.wb_dat_o, e.dat);
      end
    end
    if (bus.rd_valid_o) begin
      if (exp_rd.size() == 0) chk("rd_unexpected", bus.rd_data_o, 32'hFFFF_FFFF);
      else chk("rd_data", bus.rd_data_o, exp_rd.pop_front());
    end
    if (bus.done_o || bus.err_o) begin
      chk("end_not_both", {31'd0, bus.done_o & bus.err_o}, 32'd0);
      if (exp_end.size() == 0) chk("end_unexpected", {30'd0, bus.done_o, bus.err_o}, 32'd0);
      else chk("end_kind", {31'd0, bus.done_o}, {31'd0, exp_end.pop_front()});
    end
  end

  // Called at a falling edge with the DUT idle; returns at the falling edge where cyc should be up.
  task automatic issue(input logic we, input logic [31:0] adr, input logic [3:0] len,
                       input logic [1:0] bte, input int e_at, input int r_at);
    err_at = e_at;
    rty_at = r_at;
    bus.wr_valid_i  = 1'b0;
    bus.cmd_we_i    = we;
    bus.cmd_adr_i   = adr;
    bus.cmd_len_i   = len;
    bus.cmd_bte_i   = bte;
    bus.cmd_valid_i = 1'b1;
    chk("cmd_ready_idle", bus.cmd_ready_o, 1'b1);
    @(negedge clk);
    bus.cmd_valid_i = 1'b0;
    chk("cyc_start", bus.wb_cyc_o, 1'b1);
    chk("cmd_ready_busy", bus.cmd_ready_o, 1'b0);
  endtask

  task automatic drive_wr(input int n, input int gap_at, input int gap_len);
    bit got;
    for (int b = 0; b < n; b++) begin
      if (b == gap_at) begin
        bus.wr_valid_i = 1'b0;
        for (int g = 0; g < gap_len; g++) begin
          #1;
          chk("gap_stb_low", bus.wb_stb_o, 1'b0);
          chk("gap_cyc_high", bus.wb_cyc_o, 1'b1);
          @(negedge clk);
        end
      end
      bus.wr_valid_i = 1'b1;
      bus.wr_data_i  = 32'hD000_0000 + b;
      got = 1'b0;
      for (int t = 0; t < 20 && !got; t++) begin
        #1;
        got = bus.wr_ready_o;
        @(negedge clk);
      end
      chk("wr_beat_taken", got, 1'b1);
    end
    bus.wr_valid_i = 1'b0;
  endtask

  task automatic wait_end();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (bus.done_o || bus.err_o) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("end_seen", seen, 1'b1);
    chk("cyc_dropped", bus.wb_cyc_o, 1'b0);
    chk("stb_dropped", bus.wb_stb_o, 1'b0);
    @(negedge clk);
  endtask

  initial begin
    bus.cmd_valid_i = 1'b0;
    bus.cmd_we_i    = 1'b0;
    bus.cmd_adr_i   = '0;
    bus.cmd_len_i   = '0;
    bus.cmd_bte_i   = '0;
    bus.wr_valid_i  = 1'b0;
    bus.wr_data_i   = '0;
    repeat (3) @(negedge clk);
    chk("rst_cyc", bus.wb_cyc_o, 1'b0);
    chk("rst_done", bus.done_o, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk("init_cmd_ready", bus.cmd_ready_o, 1'b1);
    chk("init_cyc", bus.wb_cyc_o, 1'b0);
    chk("init_cti", {29'd0, bus.wb_cti_o}, 32'd0);
    chk("init_adr", bus.wb_adr_o, 32'd0);

    // Linear 4-beat read
    push_beat(32'h100, 3'b010, 1'b0, 2'b00, 32'h0);
    push_beat(32'h104, 3'b010, 1'b0, 2'b00, 32'h0);
    push_beat(32'h108, 3'b010, 1'b0, 2'b00, 32'h0);
    push_beat(32'h10C, 3'b111, 1'b0, 2'b00, 32'h0);
    exp_rd.push_back(32'h1000_0100); exp_rd.push_back(32'h1000_0104);
    exp_rd.push_back(32'h1000_0108); exp_rd.push_back(32'h1000_010C);
    exp_end.push_back(1'b1);
    issue(1'b0, 32'h100, 4'd3, 2'b00, -1, -1);
    wait_end();

    // Wrap4 write starting at the top of the block, with a 2-cycle data gap before beat 2
    push_beat(32'h1C, 3'b010, 1'b1, 2'b01, 32'hD000_0000);
    push_beat(32'h10, 3'b010, 1'b1, 2'b01, 32'hD000_0001);
    push_beat(32'h14, 3'b010, 1'b1, 2'b01, 32'hD000_0002);
    push_beat(32'h18, 3'b111, 1'b1, 2'b01, 32'hD000_0003);
    exp_end.push_back(1'b1);
    issue(1'b1, 32'h1F, 4'd3, 2'b01, -1, -1);
    drive_wr(4, 2, 2);
    wait_end();

    // Single-beat read
    push_beat(32'h40, 3'b000, 1'b0, 2'b00, 32'h0);
    exp_rd.push_back(32'h1000_0040);
    exp_end.push_back(1'b1);
    issue(1'b0, 32'h40, 4'd0, 2'b00, -1, -1);
    wait_end();

    // 8-beat read aborted by err on the fourth beat
    push_beat(32'h200, 3'b010, 1'b0, 2'b00, 32'h0);
    push_beat(32'h204, 3'b010, 1'b0, 2'b00, 32'h0);
    push_beat(32'h208, 3'b010, 1'b0, 2'b00, 32'h0);
    push_beat(32'h20C, 3'b010, 1'b0, 2'b00, 32'h0);
    exp_rd.push_back(32'h1000_0200); exp_rd.push_back(32'h1000_0204);
    exp_rd.push_back(32'h1000_0208);
    exp_end.push_back(1'b0);
    issue(1'b0, 32'h200, 4'd7, 2'b00, 3, -1);
    wait_end();

    // 4-beat write with retry on beat 2
    push_beat(32'h300, 3'b010, 1'b1, 2'b00, 32'hD000_0000);
    push_beat(32'h304, 3'b010, 1'b1, 2'b00, 32'hD000_0001);
    push_beat(32'h304, 3'b010, 1'b1, 2'b00, 32'hD000_0001);
    push_beat(32'h308, 3'b010, 1'b1, 2'b00, 32'hD000_0002);
    push_beat(32'h30C, 3'b111, 1'b1, 2'b00, 32'hD000_0003);
    exp_end.push_back(1'b1);
    issue(1'b1, 32'h300, 4'd3, 2'b00, -1, 1);
    drive_wr(4, -1, 0);
    wait_end();

    // Reset during beat 2 of an 8-beat read
    push_beat(32'h400, 3'b010, 1'b0, 2'b00, 32'h0);
    push_beat(32'h404, 3'b010, 1'b0, 2'b00, 32'h0);
    exp_rd.push_back(32'h1000_0400);
    issue(1'b0, 32'h400, 4'd7, 2'b00, -1, -1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_cyc", bus.wb_cyc_o, 1'b0);
    chk("mid_rst_stb", bus.wb_stb_o, 1'b0);
    chk("mid_rst_we", bus.wb_we_o, 1'b0);
    chk("mid_rst_cti", {29'd0, bus.wb_cti_o}, 32'd0);
    chk("mid_rst_bte", {30'd0, bus.wb_bte_o}, 32'd0);
    chk("mid_rst_adr", bus.wb_adr_o, 32'd0);
    chk("mid_rst_rd_valid", bus.rd_valid_o, 1'b0);
    chk("mid_rst_done", bus.done_o, 1'b0);
    chk("mid_rst_err", bus.err_o, 1'b0);
    chk("mid_rst_wr_ready", bus.wr_ready_o, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_cmd_ready", bus.cmd_ready_o, 1'b1);

    // Wrap8 read crossing the wrap boundary, right after reset
    push_beat(32'h51C, 3'b010, 1'b0, 2'b10, 32'h0);
    push_beat(32'h500, 3'b111, 1'b0, 2'b10, 32'h0);
    exp_rd.push_back(32'h1000_051C); exp_rd.push_back(32'h1000_0500);
    exp_end.push_back(1'b1);
    issue(1'b0, 32'h51C, 4'd1, 2'b10, -1, -1);
    wait_end();

    repeat (3) @(negedge clk);
    chk("beats_left_over", exp_beat.size(), 32'd0);
    chk("rd_left_over", exp_rd.size(), 32'd0);
    chk("end_left_over", exp_end.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/wb_b3_burst_master.md
WB_B3_BURST_MASTER -- requirements
Module: wb_b3_burst_master

Interface
REQ-001 SHALL have parameter dw, default 32, Wishbone data width (fixed 32 in this block).
REQ-002 SHALL have parameter aw, default 32, Wishbone address width.
REQ-003 SHALL have port wb_clk_i  in  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port wb_rst_i  in  1  reset, synchronous and active-high.
REQ-005 SHALL have port cmd_valid_i  in  1  command request.
REQ-006 SHALL have port cmd_ready_o  out  1  command accepted when high together with cmd_valid_i.
REQ-007 SHALL have port cmd_we_i  in  1  1 = write burst, 0 = read burst.
REQ-008 SHALL have port cmd_adr_i  in  aw  start byte address; bits [1:0] ignored.
REQ-009 SHALL have port cmd_len_i  in  4  beats minus one (0..15 means 1..16 beats).
REQ-010 SHALL have port cmd_bte_i  in  2  burst type: 00 linear, 01 wrap4, 10 wrap8, 11 wrap16.
REQ-011 SHALL have ports wr_data_i  in  dw, wr_valid_i  in  1, wr_ready_o  out  1  write-data stream.
REQ-012 SHALL have ports rd_data_o  out  dw, rd_valid_o  out  1  read-data stream, no backpressure.
REQ-013 SHALL have ports done_o  out  1 and err_o  out  1  one-cycle completion/abort pulses.
REQ-014 SHALL have Wishbone B3 master ports: wb_adr_o aw, wb_dat_o dw, wb_sel_o 4, wb_we_o 1, wb_bte_o 2, wb_cti_o 3, wb_cyc_o 1, wb_stb_o 1 (out); wb_dat_i dw, wb_ack_i 1, wb_err_i 1, wb_rty_i 1 (in).

Function
REQ-015 SHALL implement states IDLE, BUS, RTY_WAIT; cmd_ready_o = 1 only in IDLE.
REQ-016 SHALL, on cmd_valid_i & cmd_ready_o at edge N, latch command, go to BUS, and assert wb_cyc_o from cycle N+1.
REQ-017 SHALL hold wb_cyc_o high from entering BUS until the edge of the last ack or an err; one transaction per cyc.
REQ-018 SHALL drive wb_stb_o = 1 in BUS for reads; for writes wb_stb_o = wr_valid_i in BUS (combinational), wb_dat_o = wr_data_i.
REQ-019 SHALL drive wr_ready_o = wb_ack_i & wb_stb_o & wb_we_o (beat consumed on ack).
REQ-020 SHALL drive wb_sel_o = 4'hf, wb_adr_o[1:0] = 00, wb_we_o = latched cmd_we_i, wb_bte_o = latched cmd_bte_i while wb_cyc_o.
REQ-021 SHALL drive wb_cti_o = 000 when total length is 1 beat; otherwise 010 on every beat but the last, 111 on the last.
REQ-022 SHALL keep an internal beat counter; advance address and counter only on wb_ack_i & wb_stb_o.
REQ-023 SHALL advance word address by 1: bte 00 full-width add (carry into all bits); bte 01/10/11 increment only word-address bits [1:0]/[2:0]/[3:0], upper bits unchanged (wrap).
REQ-024 SHALL, on read ack, register wb_dat_i to rd_data_o and pulse rd_valid_o in the following cycle (1-cycle latency).
REQ-025 SHALL, on ack of the last beat, drop wb_cyc_o/wb_stb_o next cycle, pulse done_o that same cycle, return to IDLE.
REQ-026 SHALL, on wb_err_i with wb_stb_o, abort: drop cyc/stb next cycle, pulse err_o, no done_o, no rd_valid_o for that beat, return to IDLE.
REQ-027 SHALL, on wb_rty_i with wb_stb_o (and no ack/err), enter RTY_WAIT for one cycle with stb low, cyc high, then reissue the same beat (same address, cti).
REQ-028 SHALL give priority err > ack > rty when asserted together.
REQ-029 SHALL ignore wb_ack_i/wb_err_i/wb_rty_i when wb_stb_o is low.

Reset
REQ-030 SHALL, on wb_rst_i, go to IDLE and clear wb_cyc_o, wb_stb_o, wb_we_o, wb_cti_o, wb_bte_o, wb_adr_o, rd_valid_o, done_o, err_o, wr_ready_o to 0 at the next edge, including mid-burst (no done_o/err_o emitted).
REQ-031 SHALL present cmd_ready_o = 1 in the first cycle after reset deasserts.

Verification
REQ-032 Read, adr 0x100, len 3, bte 00, slave acks every cycle -> adr 0x100,0x104,0x108,0x10C, cti 010,010,010,111; 4 rd_valid_o pulses; done_o one cycle after last ack.
REQ-033 Write, adr 0x1C, len 3, bte 01 -> adr 0x1C,0x10,0x14,0x18; wr_valid_i low 2 cycles mid-burst holds stb low, no address skip.
REQ-034 Single read, len 0 -> cti 000, one ack, one rd_valid_o, done_o.
REQ-035 Read len 7, wb_err_i on beat 3 -> cyc drops next cycle, err_o pulse, exactly 3 rd_valid_o, no done_o.
REQ-036 wb_rty_i on beat 2 of 4-beat write -> one stb-low cycle, beat 2 reissued at same address; done_o after 4 acks.
REQ-037 wb_rst_i asserted during beat 2 of 8-beat read -> all outputs 0 next edge, cmd_ready_o 1 after release, next command runs normally.
